// File: rtl/idex_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : idex_pkg
//  Brief    : Shared state encodings, NOP constant and entry-width helper
//             for the ID->EX stage buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package idex_pkg;

   // Occupancy state of the two-slot buffer
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // A NOP control word is all zeros; replicate this bit to the control width
   localparam logic c_NOP_BIT = 1'b0;

   // Width of one stored entry: all operand words followed by the control word
   function automatic int entry_w(input int nops, input int dw, input int cw);
      return nops * dw + cw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/idex_entry_reg.sv
`default_nettype none
// ============================================================================
//  Module   : idex_entry_reg
//  Brief    : One load-enabled {data,ctrl} slot with asynchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module idex_entry_reg #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_ld,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Capture a new entry when loaded, otherwise hold; reset clears the slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_q <= '0;
      else if (i_ld)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/idex_stage_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : idex_stage_buffer
//  Brief    : ID->EX pipeline register with valid/ready handshake, two-entry
//             skid storage, synchronous flush and NOP masking of out_ctrl.
//             Optional statistics counters when IDEX_STATS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module idex_stage_buffer
   import idex_pkg::*;
#(
   parameter int DW   = 16,
   parameter int NOPS = 3,
   parameter int CW   = 16
`ifdef IDEX_STATS_EN
   ,
   parameter int CNTW = 16
`endif
) (
   input  logic               C,
   input  logic               R,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NOPS*DW-1:0] in_data,
   input  logic [CW-1:0]      in_ctrl,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NOPS*DW-1:0] out_data,
`ifdef IDEX_STATS_EN
   output logic [CW-1:0]      out_ctrl,
   output logic [CNTW-1:0]    stall_cnt,
   output logic [CNTW-1:0]    bubble_cnt
`else
   output logic [CW-1:0]      out_ctrl
`endif
);

   localparam int EW = entry_w(NOPS, DW, CW);

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic          w_in_fire;
   logic          w_out_fire;
   logic          w_ld_main;
   logic          w_ld_skid;
   logic          w_main_from_skid;
   logic [EW-1:0] w_in_entry;
   logic [EW-1:0] w_main_d;
   logic [EW-1:0] w_main_q;
   logic [EW-1:0] w_skid_q;

   // Handshake flags depend only on the state register
   assign in_ready   = (r_state != ST_FULL);
   assign out_valid  = (r_state != ST_EMPTY);
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;
   assign w_in_entry = {in_data, in_ctrl};
   assign w_main_d   = w_main_from_skid ? w_skid_q : w_in_entry;

   // Next-state and slot-load decisions; flush drops everything and loads nothing
   always_comb begin
      w_state_nxt      = r_state;
      w_ld_main        = 1'b0;
      w_ld_skid        = 1'b0;
      w_main_from_skid = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_state_nxt = ST_ONE;
                  w_ld_main   = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_ld_main = 1'b1;
               end else if (w_in_fire) begin
                  w_state_nxt = ST_FULL;
                  w_ld_skid   = 1'b1;
               end else if (w_out_fire) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  w_state_nxt      = ST_ONE;
                  w_ld_main        = 1'b1;
                  w_main_from_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Occupancy state register
   always_ff @(posedge C or posedge R) begin
      if (R)
         r_state <= ST_EMPTY;
      else
         r_state <= w_state_nxt;
   end

   idex_entry_reg #(.W(EW)) u_main (
      .clk  (C),
      .rst  (R),
      .i_ld (w_ld_main),
      .i_d  (w_main_d),
      .o_q  (w_main_q)
   );

   idex_entry_reg #(.W(EW)) u_skid (
      .clk  (C),
      .rst  (R),
      .i_ld (w_ld_skid),
      .i_d  (w_in_entry),
      .o_q  (w_skid_q)
   );

   // Operands hold their last value; control collapses to NOP when nothing is valid
   assign out_data = w_main_q[EW-1:CW];
   assign out_ctrl = out_valid ? w_main_q[CW-1:0] : {CW{c_NOP_BIT}};

`ifdef IDEX_STATS_EN
   logic [CNTW-1:0] r_stall_cnt;
   logic [CNTW-1:0] r_bubble_cnt;

   // Saturating stall/bubble counters; only reset clears them, flush does not
   always_ff @(posedge C or posedge R) begin
      if (R) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && (r_stall_cnt != {CNTW{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (!out_valid && (r_bubble_cnt != {CNTW{1'b1}}))
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_idex_stage_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idex_stage_buffer
//  Brief    : Directed and randomised checks of idex_stage_buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_idex_stage_buffer;

   localparam int DW   = 16;
   localparam int NOPS = 3;
   localparam int CW   = 16;

   logic               C = 1'b0;
   logic               R;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [NOPS*DW-1:0] in_data;
   logic [CW-1:0]      in_ctrl;
   logic               out_valid;
   logic               out_ready;
   logic [NOPS*DW-1:0] out_data;
   logic [CW-1:0]      out_ctrl;
`ifdef IDEX_STATS_EN
   logic [3:0]         stall_cnt;
   logic [3:0]         bubble_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 C = ~C;

   idex_stage_buffer #(
      .DW   (DW),
      .NOPS (NOPS),
`ifdef IDEX_STATS_EN
      .CNTW (4),
`endif
      .CW   (CW)
   ) dut (
      .C          (C),
      .R          (R),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
`ifdef IDEX_STATS_EN
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt),
`endif
      .out_ctrl   (out_ctrl)
   );

   function automatic logic [NOPS*DW-1:0] dof(input logic [15:0] w);
      return {NOPS{w}};
   endfunction

   function automatic logic [CW-1:0] cof(input logic [15:0] w);
      return w ^ 16'hC000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] w);
      in_valid = v;
      in_data  = dof(w);
      in_ctrl  = cof(w);
   endtask

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   logic [15:0] q[$];
   logic [15:0] nxt;
   logic        m_in_fire;
   logic        m_out_fire;

   initial begin
      R = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 16'h0);

      // 1: reset asserted mid-clock for two cycles
      #2 R = 1'b1;
      repeat (2) @(posedge C);
      @(negedge C);
      R = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready",  in_ready,  1'b1);
      chk("rst_out_ctrl",  out_ctrl,  0);
      chk("rst_out_data",  out_data,  0);
`ifdef IDEX_STATS_EN
      chk("rst_stall",  stall_cnt,  0);
      chk("rst_bubble", bubble_cnt, 0);
      tick();
      chk("bubble_first", bubble_cnt, 4'd1);
      chk("stall_first",  stall_cnt,  4'd0);
`endif

      // 2: streaming with out_ready=1
      out_ready = 1'b1;
      drive(1'b1, 16'h0001); tick();
      chk("st1_valid", out_valid, 1'b1);
      chk("st1_data",  out_data,  dof(16'h0001));
      chk("st1_ctrl",  out_ctrl,  cof(16'h0001));
      drive(1'b1, 16'h0002); tick();
      chk("st2_data",  out_data,  dof(16'h0002));
      chk("st2_valid", out_valid, 1'b1);
      drive(1'b1, 16'h0003); tick();
      chk("st3_data",  out_data,  dof(16'h0003));
      chk("st3_ready", in_ready,  1'b1);
      drive(1'b0, 16'h0000); tick();
      chk("st_end_valid", out_valid, 1'b0);
      chk("st_end_ctrl",  out_ctrl,  0);
      chk("st_end_hold",  out_data,  dof(16'h0003));

      // 3: back-pressure fills the skid slot, then drains in order
      out_ready = 1'b0;
      drive(1'b1, 16'h00A1); tick();
      chk("bp_a1_data", out_data, dof(16'h00A1));
      chk("bp_a1_rdy",  in_ready, 1'b1);
      drive(1'b1, 16'h00A2); tick();
      chk("bp_full_rdy", in_ready, 1'b0);
      chk("bp_full_data", out_data, dof(16'h00A1));
      drive(1'b1, 16'h00A3); tick();
      chk("bp_hold_rdy",  in_ready, 1'b0);
      chk("bp_hold_data", out_data, dof(16'h00A1));
      out_ready = 1'b1; tick();
      chk("bp_a2_data", out_data, dof(16'h00A2));
      chk("bp_a2_ctrl", out_ctrl, cof(16'h00A2));
      chk("bp_a2_rdy",  in_ready, 1'b1);
      tick();
      chk("bp_a3_data", out_data, dof(16'h00A3));
      drive(1'b0, 16'h0000); tick();
      chk("bp_end_valid", out_valid, 1'b0);
      chk("bp_end_rdy",   in_ready,  1'b1);

      // 4: flush from FULL with a pending input, then from ONE with an accepted input
      out_ready = 1'b0;
      drive(1'b1, 16'h00A1); tick();
      drive(1'b1, 16'h00A2); tick();
      chk("fl_full_rdy", in_ready, 1'b0);
      flush = 1'b1; drive(1'b1, 16'h00B1); tick();
      flush = 1'b0; drive(1'b0, 16'h0000);
      chk("fl_valid", out_valid, 1'b0);
      chk("fl_ctrl",  out_ctrl,  0);
      chk("fl_rdy",   in_ready,  1'b1);
      out_ready = 1'b1; tick();
      chk("fl_stay_empty", out_valid, 1'b0);
      out_ready = 1'b0;
      drive(1'b1, 16'h00C1); tick();
      chk("fl1_valid", out_valid, 1'b1);
      flush = 1'b1; drive(1'b1, 16'h00B2); tick();
      flush = 1'b0; drive(1'b0, 16'h0000);
      chk("fl1_valid_after", out_valid, 1'b0);
      chk("fl1_no_b2",       out_data,  dof(16'h00C1));
      tick();
      chk("fl1_stay_empty", out_valid, 1'b0);

      // 5: asynchronous reset while FULL acts before the next edge
      drive(1'b1, 16'h00D1); tick();
      drive(1'b1, 16'h00D2); tick();
      drive(1'b0, 16'h0000);
      chk("ar_pre_valid", out_valid, 1'b1);
      chk("ar_pre_rdy",   in_ready,  1'b0);
      #3 R = 1'b1;
      #1;
      chk("ar_valid", out_valid, 1'b0);
      chk("ar_rdy",   in_ready,  1'b1);
      chk("ar_data",  out_data,  0);
      chk("ar_ctrl",  out_ctrl,  0);
      #2 R = 1'b0;
      tick();
      chk("ar_after_valid", out_valid, 1'b0);

      // Random valid/ready against a FIFO scoreboard
      nxt = 16'h0100;
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 1)), nxt);
         out_ready = 1'($urandom_range(0, 1));
         chk("sw_valid", out_valid, (q.size() != 0));
         chk("sw_ready", in_ready,  (q.size() < 2));
         if (q.size() != 0) begin
            chk("sw_data", out_data, dof(q[0]));
            chk("sw_ctrl", out_ctrl, cof(q[0]));
         end
         m_in_fire  = in_valid && (q.size() < 2);
         m_out_fire = out_ready && (q.size() != 0);
         tick();
         if (m_out_fire) void'(q.pop_front());
         if (m_in_fire) begin
            q.push_back(nxt);
            nxt = nxt + 16'h1;
         end
      end
      drive(1'b0, 16'h0000);
      out_ready = 1'b1;
      repeat (3) tick();
      chk("sw_drained", out_valid, 1'b0);

`ifdef IDEX_STATS_EN
      // 6: saturation and flush immunity of the counters
      out_ready = 1'b0;
      repeat (16) tick();
      chk("ss_bubble_sat", bubble_cnt, 4'hF);
      R = 1'b1; #2 R = 1'b0;
      chk("ss_rst_stall",  stall_cnt,  4'h0);
      chk("ss_rst_bubble", bubble_cnt, 4'h0);
      drive(1'b1, 16'h0011); tick();
      drive(1'b0, 16'h0000);
      chk("ss_stall0",  stall_cnt,  4'h0);
      chk("ss_bubble1", bubble_cnt, 4'h1);
      repeat (3) tick();
      chk("ss_stall3", stall_cnt, 4'h3);
      repeat (17) tick();
      chk("ss_stall_sat", stall_cnt, 4'hF);
      flush = 1'b1; tick();
      flush = 1'b0;
      chk("ss_fl_stall",  stall_cnt,  4'hF);
      chk("ss_fl_bubble", bubble_cnt, 4'h1);
      tick();
      chk("ss_bubble2", bubble_cnt, 4'h2);
      chk("ss_stall_kept", stall_cnt, 4'hF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
